// File: rtl/accel_pkg.sv
// Shared types and constants for the accelerometer sample filter.
package accel_pkg;

    localparam int AXIS_W = 16;

    typedef enum logic [3:0] {
        WAIT_READY   = 4'd0,
        IDLE         = 4'd1,
        FETCH        = 4'd2,
        WAIT_BUSY_HI = 4'd3,
        WAIT_BUSY_LO = 4'd4,
        CAPTURE      = 4'd5,
        UPDATE       = 4'd6,
        OUTPUT       = 4'd7
    } state_e;

    // Bits needed to hold every value 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/moving_avg_axis.sv
// One axis of the moving-average filter: history ring, running sum and
// the arithmetic-shift average.
module moving_avg_axis
    import accel_pkg::*;
#(
    parameter int LOG2_DEPTH = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [AXIS_W-1:0]     sample,
    input  logic                         capture,
    input  logic                         update,
    input  logic        [LOG2_DEPTH-1:0] wr_ptr,
    output logic signed [AXIS_W-1:0]     avg
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = AXIS_W + LOG2_DEPTH;

    logic signed [AXIS_W-1:0] hist_q [DEPTH];
    logic signed [AXIS_W-1:0] hist_d [DEPTH];
    logic signed [AXIS_W-1:0] smp_new_q, smp_new_d;
    logic signed [AXIS_W-1:0] smp_old_q, smp_old_d;
    logic signed [SUM_W-1:0]  sum_q, sum_d;
    logic signed [AXIS_W-1:0] avg_q, avg_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q    <= '{default: '0};
            smp_new_q <= '0;
            smp_old_q <= '0;
            sum_q     <= '0;
            avg_q     <= '0;
        end else begin
            hist_q    <= hist_d;
            smp_new_q <= smp_new_d;
            smp_old_q <= smp_old_d;
            sum_q     <= sum_d;
            avg_q     <= avg_d;
        end
    end

    always_comb begin
        hist_d    = hist_q;
        smp_new_d = smp_new_q;
        smp_old_d = smp_old_q;
        sum_d     = sum_q;
        avg_d     = avg_q;
        if (capture) begin
            smp_new_d = sample;
            smp_old_d = hist_q[wr_ptr];
        end
        // The average is registered from the new sum so it is already stable
        // during the cycle the top level strobes filt_valid.
        if (update) begin
            sum_d          = sum_q + SUM_W'(smp_new_q) - SUM_W'(smp_old_q);
            hist_d[wr_ptr] = smp_new_q;
            avg_d          = AXIS_W'(sum_d >>> LOG2_DEPTH);
        end
    end

    assign avg = avg_q;

endmodule

// File: rtl/accel_sample_filter.sv
// Polls the ADXL345 SPI controller and produces per-axis moving averages.
//
// state        | meaning
// WAIT_READY   | wait for controller configured and idle
// IDLE         | period countdown before the next fetch
// FETCH        | one-cycle fetch request, timeout counter cleared
// WAIT_BUSY_HI | wait for controller to accept the request
// WAIT_BUSY_LO | wait for the read transaction to finish
// CAPTURE      | latch new samples and the oldest history entries
// UPDATE       | update running sums, history, write pointer, count
// OUTPUT       | filt_valid strobe, back to IDLE
module accel_sample_filter
    import accel_pkg::*;
#(
    parameter int PERIOD_CYCLES  = 50000,
    parameter int LOG2_DEPTH     = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     dev_ready,
    input  logic                     dev_busy,
    input  logic signed [AXIS_W-1:0] x_in,
    input  logic signed [AXIS_W-1:0] y_in,
    input  logic signed [AXIS_W-1:0] z_in,
    output logic                     fetch,
    output logic signed [AXIS_W-1:0] filt_x,
    output logic signed [AXIS_W-1:0] filt_y,
    output logic signed [AXIS_W-1:0] filt_z,
    output logic                     filt_valid,
    output logic                     primed,
    output logic                     timeout_err
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int PER_W = cnt_width(PERIOD_CYCLES);
    localparam int TO_W  = cnt_width(TIMEOUT_CYCLES);
    localparam int CNT_W = LOG2_DEPTH + 1;

    localparam logic [PER_W-1:0] PER_LOAD = PER_W'(PERIOD_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    state_e                state_q, state_d;
    logic [PER_W-1:0]      per_cnt_q, per_cnt_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      smp_cnt_q, smp_cnt_d;
    logic                  primed_q, primed_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  capture, update;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= WAIT_READY;
            per_cnt_q     <= '0;
            to_cnt_q      <= '0;
            wr_ptr_q      <= '0;
            smp_cnt_q     <= '0;
            primed_q      <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            per_cnt_q     <= per_cnt_d;
            to_cnt_q      <= to_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            smp_cnt_q     <= smp_cnt_d;
            primed_q      <= primed_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        per_cnt_d     = per_cnt_q;
        to_cnt_d      = to_cnt_q;
        wr_ptr_d      = wr_ptr_q;
        smp_cnt_d     = smp_cnt_q;
        primed_d      = primed_q;
        timeout_err_d = timeout_err_q;
        capture       = 1'b0;
        update        = 1'b0;
        fetch         = 1'b0;
        filt_valid    = 1'b0;
        case (state_q)
            WAIT_READY: begin
                if (dev_ready && !dev_busy) begin
                    state_d   = IDLE;
                    per_cnt_d = PER_LOAD;
                end
            end
            IDLE: begin
                if (per_cnt_q != '0) begin
                    per_cnt_d = per_cnt_q - PER_W'(1);
                end else if (enable) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                fetch    = 1'b1;
                to_cnt_d = '0;
                state_d  = WAIT_BUSY_HI;
            end
            // A late busy edge on the final allowed cycle still counts as progress.
            WAIT_BUSY_HI: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (dev_busy) begin
                    state_d = WAIT_BUSY_LO;
                end else if (to_cnt_q >= TO_LAST) begin
                    state_d       = WAIT_READY;
                    timeout_err_d = 1'b1;
                end
            end
            WAIT_BUSY_LO: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (!dev_busy) begin
                    state_d = CAPTURE;
                end else if (to_cnt_q >= TO_LAST) begin
                    state_d       = WAIT_READY;
                    timeout_err_d = 1'b1;
                end
            end
            CAPTURE: begin
                capture = 1'b1;
                state_d = UPDATE;
            end
            UPDATE: begin
                update   = 1'b1;
                wr_ptr_d = wr_ptr_q + LOG2_DEPTH'(1);
                if (smp_cnt_q != CNT_FULL) begin
                    smp_cnt_d = smp_cnt_q + CNT_W'(1);
                end
                if (smp_cnt_d == CNT_FULL) begin
                    primed_d = 1'b1;
                end
                state_d = OUTPUT;
            end
            OUTPUT: begin
                filt_valid = 1'b1;
                per_cnt_d  = PER_LOAD;
                state_d    = IDLE;
            end
            default: state_d = WAIT_READY;
        endcase
    end

    moving_avg_axis #(.LOG2_DEPTH(LOG2_DEPTH)) u_avg_x (
        .clk     (clk),
        .reset   (reset),
        .sample  (x_in),
        .capture (capture),
        .update  (update),
        .wr_ptr  (wr_ptr_q),
        .avg     (filt_x)
    );

    moving_avg_axis #(.LOG2_DEPTH(LOG2_DEPTH)) u_avg_y (
        .clk     (clk),
        .reset   (reset),
        .sample  (y_in),
        .capture (capture),
        .update  (update),
        .wr_ptr  (wr_ptr_q),
        .avg     (filt_y)
    );

    moving_avg_axis #(.LOG2_DEPTH(LOG2_DEPTH)) u_avg_z (
        .clk     (clk),
        .reset   (reset),
        .sample  (z_in),
        .capture (capture),
        .update  (update),
        .wr_ptr  (wr_ptr_q),
        .avg     (filt_z)
    );

    assign primed      = primed_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_accel_sample_filter.sv
// Self-checking bench for accel_sample_filter with a behavioural window-average
// model and an inline SPI-controller handshake model.
module tb_accel_sample_filter;

    localparam int PERIOD = 10;
    localparam int LOG2D  = 3;
    localparam int DEPTH  = 8;
    localparam int TMO    = 200;
    localparam int FETCH_BOUND = 4 * PERIOD + 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        dev_ready = 1'b0;
    logic        dev_busy = 1'b1;
    logic [15:0] x_in = '0, y_in = '0, z_in = '0;
    logic        fetch, filt_valid, primed, timeout_err;
    logic [15:0] filt_x, filt_y, filt_z;

    int checks = 0;
    int failures = 0;
    int win_x[$], win_y[$], win_z[$];

    always #5 clk = ~clk;

    accel_sample_filter #(
        .PERIOD_CYCLES  (PERIOD),
        .LOG2_DEPTH     (LOG2D),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .dev_ready   (dev_ready),
        .dev_busy    (dev_busy),
        .x_in        (x_in),
        .y_in        (y_in),
        .z_in        (z_in),
        .fetch       (fetch),
        .filt_x      (filt_x),
        .filt_y      (filt_y),
        .filt_z      (filt_z),
        .filt_valid  (filt_valid),
        .primed      (primed),
        .timeout_err (timeout_err)
    );

    // Mean of the last DEPTH samples (missing ones are zero), rounded toward -inf.
    function automatic int floor_avg(input int q[$]);
        int s = 0;
        foreach (q[i]) s += q[i];
        if (s >= 0) return s / DEPTH;
        return -((-s + DEPTH - 1) / DEPTH);
    endfunction

    function void model_clear();
        win_x.delete();
        win_y.delete();
        win_z.delete();
    endfunction

    function void model_push(input logic [15:0] xv, input logic [15:0] yv, input logic [15:0] zv);
        win_x.push_back(int'($signed(xv)));
        win_y.push_back(int'($signed(yv)));
        win_z.push_back(int'($signed(zv)));
        if (win_x.size() > DEPTH) void'(win_x.pop_front());
        if (win_y.size() > DEPTH) void'(win_y.pop_front());
        if (win_z.size() > DEPTH) void'(win_z.pop_front());
    endfunction

    task automatic hw_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    // One complete controller transaction; 'fetched' means the caller already saw fetch.
    task automatic run_txn(input logic [15:0] xv, input logic [15:0] yv, input logic [15:0] zv,
                           input int busy_len, input bit drop_en, input bit fetched);
        bit ok;
        logic [15:0] ex, ey, ez;
        bit ep;
        ok = fetched;
        if (!fetched) begin
            for (int i = 0; i < FETCH_BOUND && !ok; i++) begin
                @(negedge clk);
                if (fetch === 1'b1) ok = 1'b1;
            end
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL fetch_wait: fetch=0 for %0d cycles, expected 1", FETCH_BOUND);
                return;
            end
        end
        if (drop_en) enable = 1'b0;
        x_in = 16'($urandom);
        y_in = 16'($urandom);
        z_in = 16'($urandom);
        @(negedge clk);
        checks++;
        if (fetch !== 1'b0) begin
            failures++;
            $display("FAIL fetch_pulse: fetch=%b one cycle later, expected 0", fetch);
        end
        dev_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        x_in = xv;
        y_in = yv;
        z_in = zv;
        dev_busy = 1'b0;
        model_push(xv, yv, zv);
        ex = 16'(floor_avg(win_x));
        ey = 16'(floor_avg(win_y));
        ez = 16'(floor_avg(win_z));
        ep = (win_x.size() == DEPTH);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 3) begin
                checks++;
                if (filt_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL filt_valid_latency: got %b at busy-low+3, expected 1", filt_valid);
                end
                checks++;
                if (filt_x !== ex) begin
                    failures++;
                    $display("FAIL filt_x: got %h expected %h", filt_x, ex);
                end
                checks++;
                if (filt_y !== ey) begin
                    failures++;
                    $display("FAIL filt_y: got %h expected %h", filt_y, ey);
                end
                checks++;
                if (filt_z !== ez) begin
                    failures++;
                    $display("FAIL filt_z: got %h expected %h", filt_z, ez);
                end
                checks++;
                if (primed !== ep) begin
                    failures++;
                    $display("FAIL primed: got %b expected %b", primed, ep);
                end
            end else begin
                checks++;
                if (filt_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL filt_valid_stray: got %b at busy-low+%0d, expected 0", filt_valid, k);
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({filt_x, filt_y, filt_z, filt_valid, primed, timeout_err, fetch} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {filt_x, filt_y, filt_z, filt_valid, primed, timeout_err, fetch});
        end
    endtask

    task automatic test_startup();
        int nf = 0;
        int bad = 0;
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fetch === 1'b1) nf++;
        end
        checks++;
        if (nf != 0) begin
            failures++;
            $display("FAIL fetch_before_ready: got %0d fetches expected 0", nf);
        end
        dev_ready = 1'b1;
        dev_busy  = 1'b0;
        for (int k = 1; k <= PERIOD + 1; k++) begin
            @(negedge clk);
            if (fetch !== (k == PERIOD + 1)) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL first_fetch: %0d cycles wrong, expected fetch only at cycle %0d", bad, PERIOD + 1);
        end
    endtask

    task automatic test_handshake();
        run_txn(16'h0100, 16'hFF00, 16'h0008, 40, 1'b0, 1'b1);
        checks++;
        if ({filt_x, filt_y, filt_z, primed} !== {16'h0020, 16'hFFE0, 16'h0001, 1'b0}) begin
            failures++;
            $display("FAIL handshake_values: got %h %h %h %b expected 0020 ffe0 0001 0",
                     filt_x, filt_y, filt_z, primed);
        end
    endtask

    task automatic test_steady();
        hw_reset();
        for (int i = 0; i < 16; i++) begin
            run_txn((i < 8) ? 16'd800 : 16'hFCE0, 16'($urandom), 16'($urandom),
                    int'($urandom_range(2, 30)), 1'b0, 1'b0);
            if (i == 6) begin
                checks++;
                if (primed !== 1'b0) begin
                    failures++;
                    $display("FAIL primed_early: got %b after 7 samples expected 0", primed);
                end
            end
            if (i == 7) begin
                checks++;
                if (filt_x !== 16'd800 || primed !== 1'b1) begin
                    failures++;
                    $display("FAIL steady_8: got %h/%b expected 0320/1", filt_x, primed);
                end
            end
            if (i == 11) begin
                checks++;
                if (filt_x !== 16'h0000) begin
                    failures++;
                    $display("FAIL steady_12: got %h expected 0000", filt_x);
                end
            end
            if (i == 15) begin
                checks++;
                if (filt_x !== 16'hFCE0) begin
                    failures++;
                    $display("FAIL steady_16: got %h expected fce0", filt_x);
                end
            end
        end
    endtask

    task automatic test_extremes();
        hw_reset();
        for (int i = 0; i < 16; i++) begin
            run_txn((i < 8) ? 16'h7FFF : 16'h8000, (i < 8) ? 16'h8000 : 16'h7FFF,
                    16'($urandom), int'($urandom_range(2, 20)), 1'b0, 1'b0);
            if (i == 7) begin
                checks++;
                if (filt_x !== 16'h7FFF || filt_y !== 16'h8000) begin
                    failures++;
                    $display("FAIL extreme_max: got %h/%h expected 7fff/8000", filt_x, filt_y);
                end
            end
            if (i == 15) begin
                checks++;
                if (filt_x !== 16'h8000 || filt_y !== 16'h7FFF) begin
                    failures++;
                    $display("FAIL extreme_min: got %h/%h expected 8000/7fff", filt_x, filt_y);
                end
            end
        end
    endtask

    task automatic test_timeout();
        bit ok = 1'b0;
        int err_at = -1;
        int nv = 0;
        int nf = 0;
        for (int i = 0; i < FETCH_BOUND && !ok; i++) begin
            @(negedge clk);
            if (fetch === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL timeout_fetch: fetch=0 for %0d cycles, expected 1", FETCH_BOUND);
        end
        for (int k = 1; k <= TMO + 40; k++) begin
            @(negedge clk);
            if (filt_valid === 1'b1) nv++;
            if (fetch === 1'b1) nf++;
            if (timeout_err === 1'b1 && err_at < 0) err_at = k;
            dev_busy = 1'b1;
        end
        checks++;
        if (err_at < TMO || err_at > TMO + 2) begin
            failures++;
            $display("FAIL timeout_time: got err at cycle %0d expected %0d..%0d", err_at, TMO, TMO + 2);
        end
        checks++;
        if (nv != 0 || nf != 0) begin
            failures++;
            $display("FAIL timeout_quiet: got %0d valids %0d fetches expected 0 0", nv, nf);
        end
        dev_busy = 1'b0;
        run_txn(16'($urandom), 16'($urandom), 16'($urandom), 25, 1'b0, 1'b0);
        checks++;
        if (timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky: got %b expected 1", timeout_err);
        end
    endtask

    task automatic test_reset_mid();
        bit ok = 1'b0;
        int nf = 0;
        int bad = 0;
        for (int i = 0; i < FETCH_BOUND && !ok; i++) begin
            @(negedge clk);
            if (fetch === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL resetmid_fetch: fetch=0 for %0d cycles, expected 1", FETCH_BOUND);
        end
        @(negedge clk);
        dev_busy = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({filt_x, filt_y, filt_z, filt_valid, primed, timeout_err, fetch} !== '0) begin
            failures++;
            $display("FAIL resetmid_outputs: got %h expected 0",
                     {filt_x, filt_y, filt_z, filt_valid, primed, timeout_err, fetch});
        end
        reset = 1'b0;
        model_clear();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (fetch === 1'b1) nf++;
        end
        checks++;
        if (nf != 0) begin
            failures++;
            $display("FAIL resetmid_busy_hold: got %0d fetches expected 0", nf);
        end
        dev_busy = 1'b0;
        for (int k = 1; k <= PERIOD + 1; k++) begin
            @(negedge clk);
            if (fetch !== (k == PERIOD + 1)) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL resetmid_refetch: %0d cycles wrong, expected fetch only at cycle %0d", bad, PERIOD + 1);
        end
        run_txn(16'($urandom), 16'($urandom), 16'($urandom), 12, 1'b0, 1'b1);
    endtask

    task automatic test_enable_drop();
        int nf = 0;
        bit ok = 1'b0;
        run_txn(16'($urandom), 16'($urandom), 16'($urandom), 20, 1'b1, 1'b0);
        for (int i = 0; i < 5 * PERIOD; i++) begin
            @(negedge clk);
            if (fetch === 1'b1) nf++;
        end
        checks++;
        if (nf != 0) begin
            failures++;
            $display("FAIL enable_hold: got %0d fetches expected 0", nf);
        end
        enable = 1'b1;
        for (int i = 0; i < 3 && !ok; i++) begin
            @(negedge clk);
            if (fetch === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL enable_resume: fetch=0 within 3 cycles, expected 1");
        end
        if (ok) run_txn(16'($urandom), 16'($urandom), 16'($urandom), 8, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_startup();
        test_handshake();
        test_steady();
        test_extremes();
        test_timeout();
        test_reset_mid();
        test_enable_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at 2 ms, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
